// File: rtl/counter4_ctrl_if.sv
// Control/status bundle between the register block (master) and the
// 4-bit run controller (slave).
interface counter4_ctrl_if;
  // Controls are plain levels sampled on every rising clk edge; there is no
  // valid/ready pairing. start/stop act in the cycle they are seen high,
  // pause freezes the run for as long as it is high, mode/load_val/term_val
  // only matter in the cycle start is accepted. All status outputs are
  // registered and valid after each edge.
  logic       start;
  logic       stop;
  logic       pause;
  logic       mode;
  logic [3:0] load_val;
  logic [3:0] term_val;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [3:0] reload_cnt;
  logic [1:0] dbg_state;

  modport master (
    output start, stop, pause, mode, load_val, term_val,
    input  count, busy, done, reload_cnt, dbg_state
  );

  modport slave (
    input  start, stop, pause, mode, load_val, term_val,
    output count, busy, done, reload_cnt, dbg_state
  );
endinterface

// File: rtl/counter4_ctrl.sv
// Run controller for a 4-bit up counter: prescaled stepping, programmable
// terminal value, one-shot or auto-reload, with busy/done/reload status.
module counter4_ctrl #(
  parameter int PRESCALE = 4,
  parameter int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic               clk,
  input  logic               Reset,
  counter4_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_count;
  logic [PW-1:0]   r_presc;
  logic [3:0]      r_load_q;
  logic [3:0]      r_term_q;
  logic            r_mode_q;
  logic [3:0]      r_reload_cnt;
  logic            r_done;

  state_t          w_state_nxt;
  logic [3:0]      w_count_nxt;
  logic [PW-1:0]   w_presc_nxt;
  logic [3:0]      w_load_nxt;
  logic [3:0]      w_term_nxt;
  logic            w_mode_nxt;
  logic [3:0]      w_reload_nxt;
  logic            w_done_nxt;
  logic            w_restart;
  logic            w_tick;
  logic            w_terminal;

  assign w_tick     = (r_state == S_RUN) && (r_presc == PW'(PRESCALE - 1));
  assign w_terminal = w_tick && (r_count == r_term_q);

  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_presc_nxt  = r_presc;
    w_load_nxt   = r_load_q;
    w_term_nxt   = r_term_q;
    w_mode_nxt   = r_mode_q;
    w_reload_nxt = r_reload_cnt;
    w_done_nxt   = 1'b0;
    w_restart    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) w_restart = 1'b1;
      end
      S_RUN: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (bus.start) begin
          w_restart = 1'b1;
        end else begin
          if (w_tick) begin
            w_presc_nxt = '0;
            if (w_terminal) begin
              w_done_nxt = 1'b1;
              if (r_mode_q) begin
                w_count_nxt = r_load_q;
                if (r_reload_cnt != 4'd15) w_reload_nxt = r_reload_cnt + 4'd1;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_count_nxt = r_count + 4'd1;
            end
          end else begin
            w_presc_nxt = r_presc + PW'(1);
          end
          // A one-shot run that finishes this cycle ends in IDLE even if pause is up.
          if (bus.pause && !(w_terminal && !r_mode_q)) w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (bus.stop) begin
          w_state_nxt = S_IDLE;
        end else if (bus.start) begin
          w_restart = 1'b1;
        end else if (!bus.pause) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_restart) begin
      w_state_nxt  = S_RUN;
      w_count_nxt  = bus.load_val;
      w_load_nxt   = bus.load_val;
      w_term_nxt   = bus.term_val;
      w_mode_nxt   = bus.mode;
      w_presc_nxt  = '0;
      w_reload_nxt = 4'd0;
      w_done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_count      <= 4'd0;
      r_presc      <= '0;
      r_load_q     <= 4'd0;
      r_term_q     <= 4'd0;
      r_mode_q     <= 1'b0;
      r_reload_cnt <= 4'd0;
      r_done       <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_presc      <= w_presc_nxt;
      r_load_q     <= w_load_nxt;
      r_term_q     <= w_term_nxt;
      r_mode_q     <= w_mode_nxt;
      r_reload_cnt <= w_reload_nxt;
      r_done       <= w_done_nxt;
    end
  end

  assign bus.count      = r_count;
  assign bus.busy       = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.done       = r_done;
  assign bus.reload_cnt = r_reload_cnt;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_counter4_ctrl.sv
// Bench for counter4_ctrl: a PRESCALE=4 and a PRESCALE=1 instance checked
// cycle by cycle against a closed-form model of the run timeline.
module tb_counter4_ctrl;
  logic clk;
  logic Reset;
  int   checks;
  int   failures;

  counter4_ctrl_if if4 ();
  counter4_ctrl_if if1 ();

  counter4_ctrl #(.PRESCALE(4)) dut4 (.clk(clk), .Reset(Reset), .bus(if4));
  counter4_ctrl #(.PRESCALE(1)) dut1 (.clk(clk), .Reset(Reset), .bus(if1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_in(input bit sel, input logic st, input logic sp, input logic pa,
                        input logic md, input logic [3:0] lv, input logic [3:0] tv);
    if (sel) begin
      if1.start = st; if1.stop = sp; if1.pause = pa; if1.mode = md;
      if1.load_val = lv; if1.term_val = tv;
    end else begin
      if4.start = st; if4.stop = sp; if4.pause = pa; if4.mode = md;
      if4.load_val = lv; if4.term_val = tv;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] obs(input bit sel);
    if (sel) return {if1.count, if1.busy, if1.done, if1.reload_cnt};
    return {if4.count, if4.busy, if4.done, if4.reload_cnt};
  endfunction

  // Expected {count, busy, done, reload_cnt} k active clocks after the start edge.
  function automatic logic [9:0] model(input int k, input int p, input int l, input int m,
                                       input bit md);
    int n, t, r, s;
    logic [3:0] c, rl;
    logic d;
    n = ((m - l) & 15) + 1;
    t = n * p;
    if (!md) begin
      if (k < t) begin
        c = 4'((l + k / p) & 15);
        return {c, 1'b1, 1'b0, 4'd0};
      end
      c = 4'(m);
      d = (k == t);
      return {c, 1'b0, d, 4'd0};
    end
    r  = k / t;
    s  = (k % t) / p;
    c  = 4'((l + s) & 15);
    d  = (k > 0) && (k % t == 0);
    rl = 4'((r > 15) ? 15 : r);
    return {c, 1'b1, d, rl};
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    for (int s = 0; s < 2; s++) begin
      got = obs(s[0]);
      checks++;
      if (got !== 10'd0) begin
        failures++;
        $display("FAIL reset_held sel=%0d got=%h exp=%h", s, got, 10'd0);
      end
    end
    #3 Reset = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      got = obs(s[0]);
      checks++;
      if (got !== 10'd0) begin
        failures++;
        $display("FAIL reset_idle sel=%0d got=%h exp=%h", s, got, 10'd0);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [9:0] got, exp;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd6);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 4'd6);
    for (int k = 0; k <= 22; k++) begin
      if (k > 0) tick();
      exp = model(k, 4, 3, 6, 1'b0);
      got = obs(1'b0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL oneshot k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_autoreload();
    logic [9:0] got, exp;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd14, 4'd1);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd14, 4'd1);
    for (int k = 0; k <= 70; k++) begin
      if (k > 0) tick();
      exp = model(k, 1, 14, 1, 1'b1);
      got = obs(1'b1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL autoreload k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_pause();
    logic [9:0] got, exp;
    int ke;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9);
    for (int k = 0; k <= 50; k++) begin
      if (k > 0) tick();
      // pause seen at edges 10..14, so edges 11..15 make no progress
      ke  = k - ((k <= 10) ? 0 : ((k >= 15) ? 5 : k - 10));
      exp = model(ke, 4, 0, 9, 1'b0);
      got = obs(1'b0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pause k=%0d got=%h exp=%h", k, got, exp);
      end
      if (k == 9)  if4.pause = 1'b1;
      if (k == 14) if4.pause = 1'b0;
    end
  endtask

  task automatic test_stop_terminal();
    logic [9:0] got, exp;
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2);
    for (int k = 0; k <= 2; k++) begin
      if (k > 0) tick();
      exp = model(k, 1, 0, 2, 1'b0);
      got = obs(1'b1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL stop_run k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    if1.stop = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if1.stop = 1'b0;
      got = obs(1'b1);
      checks++;
      if (got !== {4'd2, 1'b0, 1'b0, 4'd0}) begin
        failures++;
        $display("FAIL stop_terminal k=%0d got=%h exp=%h", k, got, {4'd2, 1'b0, 1'b0, 4'd0});
      end
    end
  endtask

  task automatic test_restart();
    logic [9:0] got, exp;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5);
    for (int k = 0; k <= 44; k++) begin
      if (k > 0) tick();
      exp = model(k, 4, 0, 5, 1'b1);
      got = obs(1'b0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL restart_pre k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd10, 4'd12);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 4'd12);
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) tick();
      exp = model(k, 4, 10, 12, 1'b0);
      got = obs(1'b0);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL restart k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] got, exp;
    bit sel, md;
    int p, l, m, n, len;
    for (int run = 0; run < 8; run++) begin
      sel = 1'($urandom_range(0, 1));
      md  = 1'($urandom_range(0, 1));
      l   = $urandom_range(0, 15);
      m   = $urandom_range(0, 15);
      p   = sel ? 1 : 4;
      n   = ((m - l) & 15) + 1;
      len = 2 * n * p + 3;
      if (len > 100) len = 100;
      set_in(sel, 1'b1, 1'b0, 1'b0, md, 4'(l), 4'(m));
      tick();
      set_in(sel, 1'b0, 1'b0, 1'b0, md, 4'(l), 4'(m));
      for (int k = 0; k <= len; k++) begin
        if (k > 0) tick();
        exp = model(k, p, l, m, md);
        got = obs(sel);
        checks++;
        if (got !== exp) begin
          failures++;
          $display("FAIL random run=%0d k=%0d got=%h exp=%h", run, k, got, exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] got, exp;
    int l;
    l = $urandom_range(0, 15);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(l), 4'(l + 1));
    tick();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'(l), 4'(l + 1));
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      exp = model(k, 1, l, (l + 1) & 15, 1'b1);
      got = obs(1'b1);
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL async_pre k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    #3 Reset = 1'b1;
    #1;
    got = obs(1'b1);
    checks++;
    if (got !== 10'd0) begin
      failures++;
      $display("FAIL async_reset_immediate got=%h exp=%h", got, 10'd0);
    end
    tick();
    #3 Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = obs(1'b1);
      checks++;
      if (got !== 10'd0) begin
        failures++;
        $display("FAIL async_reset_after k=%0d got=%h exp=%h", k, got, 10'd0);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    Reset    = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    #12;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_pause();
    test_stop_terminal();
    test_restart();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter4_ctrl.md
# counter4_ctrl

Run controller for the team's 4-bit up counter. It loads a start value, advances the count once every PRESCALE clocks, and detects a programmable terminal value. At terminal count it either stops (one-shot) or reloads (auto-reload). It sits between the control/register logic (start/stop/pause, operands) and the count consumer, and exposes a busy flag, a one-cycle done pulse and a saturating reload counter.

## Interface
Parameters:
- PRESCALE, default 4: clocks per count step; legal range 1..256.
- PW, default $clog2(PRESCALE) (minimum 1): prescaler register width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  reset, asynchronous, active-high.
- start  input  1  level-sampled; captures operands and begins a run.
- stop  input  1  level-sampled; aborts a run and returns to IDLE.
- pause  input  1  level; freezes the run while high.
- mode  input  1  sampled with start; 0 = one-shot, 1 = auto-reload.
- load_val  input  4  sampled with start; first count value.
- term_val  input  4  sampled with start; terminal count value.
- count  output  4  current count.
- busy  output  1  high in RUN and PAUSE.
- done  output  1  one-clock pulse per terminal event.
- reload_cnt  output  4  number of auto-reloads since start; saturates at 15.

## Operation
- Internal registers: state {IDLE, RUN, PAUSE}, load_q, term_q, mode_q, presc[PW-1:0].
- Priority of sampled controls: stop > start > pause.
- Tick: asserted in RUN when presc == PRESCALE-1. presc increments in RUN and wraps to 0 on a tick. presc holds its value in PAUSE.
- Tick with count != term_q: count <= count+1, modulo 16 (15 wraps to 0).
- Tick with count == term_q (terminal event): done <= 1 for one cycle.
  - One-shot: state <= IDLE and count holds term_q.
  - Auto-reload: count <= load_q, reload_cnt <= min(reload_cnt+1, 15), state stays RUN.
- IDLE: count holds its value. On start: count <= load_val; load_q, term_q and mode_q are captured; presc <= 0; reload_cnt <= 0; state <= RUN.
- RUN + start: restart exactly as from IDLE. A pending tick in that cycle is discarded.
- PAUSE + start: same restart as from RUN.
- RUN + pause (no stop or start): state <= PAUSE. If a tick coincides, the tick, including any terminal event, completes first.
- PAUSE + pause low: state <= RUN, and presc resumes from its held value.
- stop in RUN or PAUSE: state <= IDLE. count and reload_cnt hold. No done is issued, even if a terminal tick coincides.
- stop in IDLE: no effect.
- load_val == term_val: the first tick is a terminal event.
- term_val < load_val: counting wraps through 15 -> 0 to reach term_val.
- Reset asserted: state = IDLE, count = 0, presc = 0, load_q = term_q = 0, mode_q = 0, busy = 0, done = 0, reload_cnt = 0. These values take effect immediately and independently of clk, and hold while Reset is high.

## Timing
- Start sampled at edge E:
  - count = load_val and busy = 1 after E.
  - First tick at edge E+PRESCALE; subsequent ticks every PRESCALE edges.
- Each count value except the terminal value is held for exactly PRESCALE clocks.
- Terminal value term_q is reached at the tick edge that produces it and is held for PRESCALE clocks. The terminal event fires at the following tick edge T.
- done: high for exactly one clock after edge T.
  - One-shot: busy falls at T, in the same cycle done rises.
  - Auto-reload: busy stays high.
- Run length from load L to term M: ((M-L) mod 16 + 1) x PRESCALE clocks, from the start edge to the terminal edge.
- PRESCALE = 1: a tick occurs every RUN cycle.
- Pause latency: pause high at edge P means no tick at P+1. Each pause cycle adds one clock to the run length.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset deassertion: the first active edge is the first rising clk after Reset falls. start may be sampled on that edge.

## Test plan
- PRESCALE=4, load=3, term=6, mode=0, start at edge 0 -> count 3/4/5/6 changing at edges 0/4/8/12; done high only after edge 16; busy low from edge 16; count stays 6.
- PRESCALE=1, load=14, term=1, mode=1 -> count sequence 14,15,0,1,14,15,...; done every 4th cycle; reload_cnt 1,2,3...; reload_cnt saturates at 15 after 15 reloads.
- PRESCALE=4, load=0, term=9, mode=0; pause high for 5 cycles at count=2 mid-prescale -> count frozen at 2, busy=1, done=0; the run completes exactly 5 clocks later than an unpaused run (40 -> 45).
- PRESCALE=1, load=0, term=2; stop asserted on the terminal-tick cycle -> IDLE, busy=0, done never asserts, count holds 2.
- Restart: start during RUN at count=5 with new load=10 -> count=10 on the next edge, reload_cnt=0, presc restarted.
- Reset pulsed asynchronously between clock edges mid-run -> count=0, busy=0, done=0 and reload_cnt=0 before the next clock edge; state is IDLE and count holds 0 after Reset falls.
